// File: rtl/hwpe_cfg_dispatcher_pkg.sv
// Shared types for the HWPE config-bus dispatcher: command record, FSM states, error codes.
package hwpe_cfg_dispatcher_pkg;

  typedef enum logic [0:0] {
    CmdWrite = 1'b0,
    CmdPoll  = 1'b1
  } cmd_op_e;

  typedef struct packed {
    cmd_op_e     op;
    logic [15:0] offset;
    logic [31:0] data;
    logic [31:0] mask;
  } cmd_t;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StWaitRsp,
    StGap
  } state_e;

  typedef enum logic [1:0] {
    ErrNone        = 2'd0,
    ErrPollTimeout = 2'd1,
    ErrIdMismatch  = 2'd2
  } err_code_e;

  // A byte lane is enabled when any bit of the matching mask byte is set.
  function automatic logic [3:0] be_from_mask(input logic [31:0] mask);
    logic [3:0] be;
    for (int k = 0; k < 4; k++) begin
      be[k] = |mask[8*k +: 8];
    end
    return be;
  endfunction

endpackage

// File: rtl/hwpe_cfg_cmd_fifo.sv
// Command FIFO holding cmd_t records, with synchronous flush, full/empty flags and usage count.
module hwpe_cfg_cmd_fifo
  import hwpe_cfg_dispatcher_pkg::*;
#(
  parameter int unsigned Depth = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  cmd_t                       data_i,
  input  logic                       pop_i,
  output cmd_t                       data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(Depth):0]     usage_o
);

  localparam int unsigned AddrW = $clog2(Depth);

  cmd_t             mem_q [Depth];
  logic [AddrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AddrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AddrW:0]   usage_q, usage_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    usage_d  = usage_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      usage_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
      unique case ({push_i, pop_i})
        2'b10:   usage_d = usage_q + 1'b1;
        2'b01:   usage_d = usage_q - 1'b1;
        default: usage_d = usage_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      usage_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      usage_q  <= usage_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i && !flush_i) mem_q[wr_ptr_q] <= data_i;
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign full_o  = (usage_q == (AddrW + 1)'(Depth));
  assign empty_o = (usage_q == '0);
  assign usage_o = usage_q;

endmodule

// File: rtl/hwpe_cfg_dispatcher.sv
// Issues queued WRITE/POLL commands as single transactions on the HWPE peripheral config bus.
// Build macro HWPE_CFG_DISPATCHER_STATS_EN adds saturating write/poll statistics outputs.
module hwpe_cfg_dispatcher
  import hwpe_cfg_dispatcher_pkg::*;
#(
  parameter int unsigned ID_WIDTH   = 8,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned MAX_POLL   = 1024,
  parameter int unsigned POLL_GAP   = 4,
  parameter logic [31:0] BASE_ADDR  = 32'h0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clear_i,
  input  logic                cmd_valid_i,
  output logic                cmd_ready_o,
  input  logic                cmd_op_i,
  input  logic [15:0]         cmd_offset_i,
  input  logic [31:0]         cmd_data_i,
  input  logic [31:0]         cmd_mask_i,
  output logic                cfg_req_o,
  output logic [31:0]         cfg_add_o,
  output logic                cfg_wen_o,
  output logic [3:0]          cfg_be_o,
  output logic [31:0]         cfg_wdata_o,
  output logic [ID_WIDTH-1:0] cfg_id_o,
  input  logic                cfg_gnt_i,
  input  logic                cfg_r_valid_i,
  input  logic [31:0]         cfg_r_rdata_i,
  input  logic [ID_WIDTH-1:0] cfg_r_id_i,
`ifdef HWPE_CFG_DISPATCHER_STATS_EN
  output logic [31:0]         stat_wr_o,
  output logic [31:0]         stat_poll_o,
`endif
  output logic                busy_o,
  output logic                done_o,
  output logic                err_o,
  output logic [1:0]          err_code_o
);

  localparam int unsigned PollW = $clog2(MAX_POLL + 1);
  localparam int unsigned GapW  = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;

  state_e              state_q, state_d;
  cmd_t                cmd_q, cmd_d;
  logic [ID_WIDTH-1:0] id_q, id_d;
  logic [ID_WIDTH-1:0] issued_id_q, issued_id_d;
  logic [PollW-1:0]    attempt_q, attempt_d;
  logic [GapW-1:0]     gap_q, gap_d;
  logic                clr_pend_q, clr_pend_d;
  logic                err_q, err_d;
  err_code_e           err_code_q, err_code_d;
  logic                done_q, done_d;

  cmd_t                    fifo_in, fifo_head;
  logic                    push, pop, flush;
  logic                    fifo_full, fifo_empty;
  logic [$clog2(FIFO_DEPTH):0] fifo_usage;
  logic                    push_no_pop;
  logic                    poll_match;

  assign fifo_in = '{op: cmd_op_e'(cmd_op_i), offset: cmd_offset_i,
                     data: cmd_data_i, mask: cmd_mask_i};

  // A full FIFO still accepts when the head is popped in the same cycle.
  assign cmd_ready_o = !fifo_full || pop;
  assign push        = cmd_valid_i && cmd_ready_o && !clear_i;
  // Pop only happens in StIdle, so this form is exact wherever done_d uses it.
  assign push_no_pop = cmd_valid_i && !fifo_full && !clear_i;
  assign poll_match  = ((cfg_r_rdata_i ^ cmd_q.data) & cmd_q.mask) == 32'h0;

  hwpe_cfg_cmd_fifo #(
    .Depth (FIFO_DEPTH)
  ) u_cmd_fifo (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .flush_i (flush),
    .push_i  (push),
    .data_i  (fifo_in),
    .pop_i   (pop),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .usage_o (fifo_usage)
  );

  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    id_d        = id_q;
    issued_id_d = issued_id_q;
    attempt_d   = attempt_q;
    gap_d       = gap_q;
    clr_pend_d  = clr_pend_q;
    err_d       = err_q;
    err_code_d  = err_code_q;
    done_d      = 1'b0;
    pop         = 1'b0;
    flush       = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (clear_i) begin
          flush = 1'b1;
        end else if (!fifo_empty && !err_q) begin
          pop       = 1'b1;
          cmd_d     = fifo_head;
          attempt_d = '0;
          state_d   = StReq;
        end
      end
      StReq: begin
        if (clear_i) begin
          flush   = 1'b1;
          state_d = StIdle;
        end else if (cfg_gnt_i) begin
          issued_id_d = id_q;
          id_d        = id_q + 1'b1;
          state_d     = StWaitRsp;
        end
      end
      StWaitRsp: begin
        clr_pend_d = clr_pend_q || clear_i;
        if (cfg_r_valid_i) begin
          state_d    = StIdle;
          clr_pend_d = 1'b0;
          if (clr_pend_q || clear_i) begin
            flush = 1'b1;
          end else if (cfg_r_id_i != issued_id_q) begin
            err_d      = 1'b1;
            err_code_d = ErrIdMismatch;
          end else if (cmd_q.op == CmdWrite || poll_match) begin
            done_d = (fifo_usage == '0) && !push_no_pop;
          end else if (attempt_q == PollW'(MAX_POLL - 1)) begin
            err_d      = 1'b1;
            err_code_d = ErrPollTimeout;
          end else begin
            attempt_d = attempt_q + 1'b1;
            gap_d     = '0;
            state_d   = (POLL_GAP == 0) ? StReq : StGap;
          end
        end
      end
      StGap: begin
        if (clear_i) begin
          flush   = 1'b1;
          state_d = StIdle;
        end else if (gap_q == GapW'(POLL_GAP - 1)) begin
          state_d = StReq;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (flush) begin
      err_d      = 1'b0;
      err_code_d = ErrNone;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cmd_q       <= '0;
      id_q        <= '0;
      issued_id_q <= '0;
      attempt_q   <= '0;
      gap_q       <= '0;
      clr_pend_q  <= 1'b0;
      err_q       <= 1'b0;
      err_code_q  <= ErrNone;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      id_q        <= id_d;
      issued_id_q <= issued_id_d;
      attempt_q   <= attempt_d;
      gap_q       <= gap_d;
      clr_pend_q  <= clr_pend_d;
      err_q       <= err_d;
      err_code_q  <= err_code_d;
      done_q      <= done_d;
    end
  end

`ifdef HWPE_CFG_DISPATCHER_STATS_EN
  logic [31:0] stat_wr_q, stat_wr_d;
  logic [31:0] stat_poll_q, stat_poll_d;

  always_comb begin
    stat_wr_d   = stat_wr_q;
    stat_poll_d = stat_poll_q;
    if (clear_i) begin
      stat_wr_d   = '0;
      stat_poll_d = '0;
    end else begin
      if (state_q == StWaitRsp && cfg_r_valid_i && !clr_pend_q && cmd_q.op == CmdWrite &&
          cfg_r_id_i == issued_id_q && stat_wr_q != '1) begin
        stat_wr_d = stat_wr_q + 1'b1;
      end
      if (state_q == StReq && cfg_gnt_i && cmd_q.op == CmdPoll && stat_poll_q != '1) begin
        stat_poll_d = stat_poll_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_wr_q   <= '0;
      stat_poll_q <= '0;
    end else begin
      stat_wr_q   <= stat_wr_d;
      stat_poll_q <= stat_poll_d;
    end
  end

  assign stat_wr_o   = stat_wr_q;
  assign stat_poll_o = stat_poll_q;
`endif

  // Bus fields are held at zero outside a request so idle outputs match the reset state.
  assign cfg_req_o   = (state_q == StReq);
  assign cfg_add_o   = cfg_req_o ? (BASE_ADDR + {16'h0, cmd_q.offset}) : 32'h0;
  assign cfg_wen_o   = cfg_req_o && (cmd_q.op == CmdPoll);
  assign cfg_be_o    = !cfg_req_o ? 4'h0 :
                       (cmd_q.op == CmdPoll) ? 4'hF : be_from_mask(cmd_q.mask);
  assign cfg_wdata_o = (cfg_req_o && cmd_q.op == CmdWrite) ? cmd_q.data : 32'h0;
  assign cfg_id_o    = cfg_req_o ? id_q : '0;

  assign busy_o     = !fifo_empty || (state_q != StIdle);
  assign done_o     = done_q;
  assign err_o      = err_q;
  assign err_code_o = err_code_q;

endmodule

// File: tb/tb_hwpe_cfg_dispatcher.sv
// Directed bench for hwpe_cfg_dispatcher: decode table plus hand-written multi-cycle sequences.
module tb_hwpe_cfg_dispatcher;

  localparam int unsigned IdW = 2;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           clear_i = 1'b0;
  logic           cmd_valid_i = 1'b0;
  logic           cmd_ready_o;
  logic           cmd_op_i = 1'b0;
  logic [15:0]    cmd_offset_i = '0;
  logic [31:0]    cmd_data_i = '0;
  logic [31:0]    cmd_mask_i = '0;
  logic           cfg_req_o;
  logic [31:0]    cfg_add_o;
  logic           cfg_wen_o;
  logic [3:0]     cfg_be_o;
  logic [31:0]    cfg_wdata_o;
  logic [IdW-1:0] cfg_id_o;
  logic           cfg_gnt_i = 1'b0;
  logic           cfg_r_valid_i = 1'b0;
  logic [31:0]    cfg_r_rdata_i = '0;
  logic [IdW-1:0] cfg_r_id_i = '0;
  logic           busy_o;
  logic           done_o;
  logic           err_o;
  logic [1:0]     err_code_o;
`ifdef HWPE_CFG_DISPATCHER_STATS_EN
  logic [31:0]    stat_wr_o;
  logic [31:0]    stat_poll_o;
`endif

  hwpe_cfg_dispatcher #(
    .ID_WIDTH   (IdW),
    .FIFO_DEPTH (4),
    .MAX_POLL   (8),
    .POLL_GAP   (4),
    .BASE_ADDR  (32'h1020_0000)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .clear_i       (clear_i),
    .cmd_valid_i   (cmd_valid_i),
    .cmd_ready_o   (cmd_ready_o),
    .cmd_op_i      (cmd_op_i),
    .cmd_offset_i  (cmd_offset_i),
    .cmd_data_i    (cmd_data_i),
    .cmd_mask_i    (cmd_mask_i),
    .cfg_req_o     (cfg_req_o),
    .cfg_add_o     (cfg_add_o),
    .cfg_wen_o     (cfg_wen_o),
    .cfg_be_o      (cfg_be_o),
    .cfg_wdata_o   (cfg_wdata_o),
    .cfg_id_o      (cfg_id_o),
    .cfg_gnt_i     (cfg_gnt_i),
    .cfg_r_valid_i (cfg_r_valid_i),
    .cfg_r_rdata_i (cfg_r_rdata_i),
    .cfg_r_id_i    (cfg_r_id_i),
`ifdef HWPE_CFG_DISPATCHER_STATS_EN
    .stat_wr_o     (stat_wr_o),
    .stat_poll_o   (stat_poll_o),
`endif
    .busy_o        (busy_o),
    .done_o        (done_o),
    .err_o         (err_o),
    .err_code_o    (err_code_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        op;
    logic [15:0] off;
    logic [31:0] data;
    logic [31:0] mask;
    logic [31:0] add;
    logic [3:0]  be;
    logic        wen;
    logic [31:0] wdata;
  } vec_t;

  vec_t vecs[6];
  int   n_tests = 0;
  int   n_fail = 0;
  int   exp_id = 0;
  int   n_reads = 0;

  always @(posedge clk) begin
    if (cfg_req_o && cfg_gnt_i && cfg_wen_o) n_reads <= n_reads + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic op, input logic [15:0] off, input logic [31:0] data,
                      input logic [31:0] mask);
    cmd_valid_i  = 1'b1;
    cmd_op_i     = op;
    cmd_offset_i = off;
    cmd_data_i   = data;
    cmd_mask_i   = mask;
    tick();
    cmd_valid_i  = 1'b0;
  endtask

  task automatic wait_req(output int waited);
    waited = 0;
    while (!cfg_req_o && waited < 100) begin
      tick();
      waited++;
    end
    check("req_seen", 32'(cfg_req_o), 32'd1);
  endtask

  task automatic grant(output int id);
    id        = exp_id;
    cfg_gnt_i = 1'b1;
    tick();
    cfg_gnt_i = 1'b0;
    exp_id    = (exp_id + 1) % 4;
  endtask

  task automatic respond(input logic [31:0] rdata, input int rid);
    cfg_r_valid_i = 1'b1;
    cfg_r_rdata_i = rdata;
    cfg_r_id_i    = IdW'(rid);
    tick();
    cfg_r_valid_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w;
    int id;
    int acc;
    int seen;
    int reads0;
    logic [31:0] poll_rd[3];

    vecs[0] = '{1'b0, 16'h0020, 32'hDEAD_BEEF, 32'h0000_FFFF, 32'h1020_0020, 4'h3, 1'b0,
                32'hDEAD_BEEF};
    vecs[1] = '{1'b0, 16'h0004, 32'h1234_5678, 32'hFFFF_FFFF, 32'h1020_0004, 4'hF, 1'b0,
                32'h1234_5678};
    vecs[2] = '{1'b1, 16'h0100, 32'h0000_0005, 32'h0000_000F, 32'h1020_0100, 4'hF, 1'b1,
                32'h0};
    vecs[3] = '{1'b0, 16'hFFFC, 32'hCAFE_F00D, 32'hFF00_FF00, 32'h1020_FFFC, 4'hA, 1'b0,
                32'hCAFE_F00D};
    vecs[4] = '{1'b0, 16'h0008, 32'h0000_0001, 32'h0000_00FF, 32'h1020_0008, 4'h1, 1'b0,
                32'h0000_0001};
    vecs[5] = '{1'b1, 16'h0040, 32'h8000_0000, 32'h8000_0000, 32'h1020_0040, 4'hF, 1'b1,
                32'h0};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", 32'(cmd_ready_o), 32'd1);
    check("rst_req", 32'(cfg_req_o), 32'd0);
    check("rst_add", cfg_add_o, 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_done", 32'(done_o), 32'd0);
    check("rst_err", {29'd0, err_o, err_code_o}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Decode table; six single-shot transactions also walk the 2-bit ID through its wrap
    for (int i = 0; i < 6; i++) begin
      push(vecs[i].op, vecs[i].off, vecs[i].data, vecs[i].mask);
      wait_req(w);
      check($sformatf("v%0d_add", i), cfg_add_o, vecs[i].add);
      check($sformatf("v%0d_be", i), 32'(cfg_be_o), 32'(vecs[i].be));
      check($sformatf("v%0d_wen", i), 32'(cfg_wen_o), 32'(vecs[i].wen));
      check($sformatf("v%0d_wdata", i), cfg_wdata_o, vecs[i].wdata);
      check($sformatf("v%0d_id", i), 32'(cfg_id_o), 32'(exp_id));
      grant(id);
      check($sformatf("v%0d_req_drop", i), 32'(cfg_req_o), 32'd0);
      respond(vecs[i].data, id);
      check($sformatf("v%0d_done", i), 32'(done_o), 32'd1);
      check($sformatf("v%0d_err", i), 32'(err_o), 32'd0);
      tick();
      check($sformatf("v%0d_done_pulse", i), 32'(done_o), 32'd0);
    end

    // Delayed grant with a response in the grant cycle, which must be ignored
    push(1'b0, 16'h0020, 32'hDEAD_BEEF, 32'h0000_FFFF);
    wait_req(w);
    for (int c = 0; c < 2; c++) begin
      check("hold_add", cfg_add_o, 32'h1020_0020);
      check("hold_be", 32'(cfg_be_o), 32'h3);
      tick();
    end
    check("hold_req3", 32'(cfg_req_o), 32'd1);
    cfg_r_valid_i = 1'b1;
    cfg_r_id_i    = IdW'(exp_id);
    grant(id);
    cfg_r_valid_i = 1'b0;
    check("early_rsp_busy", 32'(busy_o), 32'd1);
    check("early_rsp_done", 32'(done_o), 32'd0);
    tick();
    check("wait_busy", 32'(busy_o), 32'd1);
    respond(32'h0, id);
    check("delayed_done", 32'(done_o), 32'd1);
    tick();

    // POLL: target returns 1,1,0 against mask 1 / expected 0
    poll_rd[0] = 32'h1;
    poll_rd[1] = 32'h1;
    poll_rd[2] = 32'h0;
    reads0 = n_reads;
    push(1'b1, 16'h0010, 32'h0, 32'h1);
    for (int a = 0; a < 3; a++) begin
      wait_req(w);
      if (a > 0) check($sformatf("poll_gap%0d", a), 32'(w), 32'd4);
      check("poll_wen", 32'(cfg_wen_o), 32'd1);
      grant(id);
      respond(poll_rd[a], id);
    end
    check("poll_done", 32'(done_o), 32'd1);
    check("poll_err", 32'(err_o), 32'd0);
    repeat (8) tick();
    check("poll_reads", 32'(n_reads - reads0), 32'd3);
    check("poll_idle", 32'(busy_o), 32'd0);

    // POLL timeout after MAX_POLL reads with a WRITE queued behind it
    reads0 = n_reads;
    push(1'b1, 16'h0014, 32'h0, 32'h1);
    push(1'b0, 16'h0018, 32'h55, 32'hFFFF_FFFF);
    for (int a = 0; a < 8; a++) begin
      wait_req(w);
      grant(id);
      respond(32'h1, id);
    end
    check("to_err", 32'(err_o), 32'd1);
    check("to_code", 32'(err_code_o), 32'd1);
    check("to_done", 32'(done_o), 32'd0);
    seen = 0;
    for (int c = 0; c < 12; c++) begin
      if (cfg_req_o) seen++;
      check("to_busy", 32'(busy_o), 32'd1);
      tick();
    end
    check("to_halt", 32'(seen), 32'd0);
    check("to_reads", 32'(n_reads - reads0), 32'd8);
    check("to_ready", 32'(cmd_ready_o), 32'd1);
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    check("to_clr_err", {29'd0, err_o, err_code_o}, 32'd0);
    check("to_clr_busy", 32'(busy_o), 32'd0);

    // Response ID mismatch with a second command left in the FIFO
    push(1'b0, 16'h0030, 32'h1, 32'hF);
    push(1'b0, 16'h0034, 32'h2, 32'hF);
    wait_req(w);
    grant(id);
    respond(32'h0, (id + 1) % 4);
    check("idm_err", 32'(err_o), 32'd1);
    check("idm_code", 32'(err_code_o), 32'd2);
    for (int c = 0; c < 4; c++) begin
      check("idm_req", 32'(cfg_req_o), 32'd0);
      check("idm_busy", 32'(busy_o), 32'd1);
      tick();
    end
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    check("idm_clr", {30'd0, err_o, busy_o}, 32'd0);

    // Fill FIFO while the head sits ungranted in REQ, then clear
    acc = 0;
    for (int i = 0; i < 8; i++) begin
      cmd_valid_i  = 1'b1;
      cmd_op_i     = 1'b0;
      cmd_offset_i = 16'(i * 4);
      cmd_mask_i   = 32'hF;
      #1;
      if (!cmd_ready_o) break;
      acc++;
      tick();
    end
    cmd_valid_i = 1'b0;
    check("full_accepted", 32'(acc), 32'd5);
    check("full_ready", 32'(cmd_ready_o), 32'd0);
    check("full_req", 32'(cfg_req_o), 32'd1);
    clear_i = 1'b1;
    #1;
    check("clr_req_same", 32'(cfg_req_o), 32'd1);
    tick();
    clear_i = 1'b0;
    check("clr_req", 32'(cfg_req_o), 32'd0);
    check("clr_busy", 32'(busy_o), 32'd0);
    check("clr_ready", 32'(cmd_ready_o), 32'd1);

    // Push coinciding with clear is discarded
    cmd_valid_i = 1'b1;
    clear_i     = 1'b1;
    tick();
    cmd_valid_i = 1'b0;
    clear_i     = 1'b0;
    check("clr_push_busy", 32'(busy_o), 32'd0);
    tick();
    check("clr_push_req", 32'(cfg_req_o), 32'd0);

    // Asynchronous reset mid-transaction
    push(1'b0, 16'h0044, 32'h9, 32'hF);
    wait_req(w);
    rst_n = 1'b0;
    #1;
    check("arst_req", 32'(cfg_req_o), 32'd0);
    check("arst_busy", 32'(busy_o), 32'd0);
    check("arst_ready", 32'(cmd_ready_o), 32'd1);
    tick();
    rst_n = 1'b1;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
